// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN converter front end: operator codes, arbiter states, clog2.
// No logic of its own; latency n/a.
// Backpressure n/a.
package rpn_pkg;

    // Operator codes carried on the token bus when is_op is set
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_EQ  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_HOLD,
        ST_GAP,
        ST_FLUSH,
        ST_DONE,
        ST_ABORT
    } arb_state_t;

    // Bits needed to index n items (at least 1)
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/rpn_rr_pick.sv
// Round-robin pick: first set request at or above ptr (mod N), one-hot and index form.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
module rpn_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt_oh,
    output logic [IDW-1:0] gnt_idx,
    output logic           any
);

    logic [IDW:0] cand;

    // Scan offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
            if (req[cand[IDW-1:0]]) begin
                gnt_idx = cand[IDW-1:0];
                any     = 1'b1;
            end
        end
        gnt_oh = any ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/rpn_session_arbiter.sv
// Shares one infix->postfix converter between N_REQ sources, one whole expression per grant.
// Latency: req_stb to cnv_stb 1 cycle; req_ack one cycle after cnv_ack.
// Backpressure: tokens held on cnv_* until cnv_ack; stalled owners are flushed with '=' after TIMEOUT idle cycles.
module rpn_session_arbiter
    import rpn_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int EQ_CODE = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          req_stb,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_is_op,
    output logic [N_REQ-1:0]          req_ack,
    output logic                      cnv_stb,
    output logic [DATA_W-1:0]         cnv_data,
    output logic                      cnv_is_op,
    input  logic                      cnv_ack,
    output logic                      grant_valid,
    output logic [clog2(N_REQ)-1:0]   grant_id,
    output logic                      session_done,
    output logic                      session_abort
);

    localparam int IDW = clog2(N_REQ);
    localparam int CW  = clog2(TIMEOUT);

    arb_state_t        state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    gid_q, gid_d;
    logic              gvld_q, gvld_d;
    logic              cnv_stb_q, cnv_stb_d;
    logic [DATA_W-1:0] cnv_data_q, cnv_data_d;
    logic              cnv_is_op_q, cnv_is_op_d;
    logic [N_REQ-1:0]  req_ack_q, req_ack_d;
    logic              done_q, done_d;
    logic              abort_q, abort_d;
    logic [CW-1:0]     idle_q, idle_d;

    logic [N_REQ-1:0]  pick_oh;
    logic [IDW-1:0]    pick_idx;
    logic              pick_any;
    logic [DATA_W-1:0] pick_data;
    logic [DATA_W-1:0] owner_data;
    logic [IDW-1:0]    ptr_next;

    rpn_rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
        .req     (req_stb),
        .ptr     (ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign pick_data  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
    assign owner_data = req_data[int'(gid_q)*DATA_W +: DATA_W];
    assign ptr_next   = (gid_q == IDW'(N_REQ - 1)) ? '0 : gid_q + 1'b1;

    // Session sequencing: grant, forward tokens, watch for '=' or an idle owner
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        gvld_d      = gvld_q;
        cnv_stb_d   = cnv_stb_q;
        cnv_data_d  = cnv_data_q;
        cnv_is_op_d = cnv_is_op_q;
        idle_d      = idle_q;
        req_ack_d   = '0;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gid_d       = pick_idx;
                    gvld_d      = 1'b1;
                    cnv_stb_d   = 1'b1;
                    cnv_data_d  = pick_data;
                    cnv_is_op_d = |(req_is_op & pick_oh);
                    state_d     = ST_FWD;
                end
            end
            ST_FWD: begin
                if (cnv_ack) begin
                    cnv_stb_d = 1'b0;
                    req_ack_d = N_REQ'(1) << gid_q;
                    state_d   = (cnv_is_op_q && cnv_data_q == DATA_W'(EQ_CODE)) ? ST_DONE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Owner is still seeing its ack and retiring the old token
                idle_d  = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (req_stb[gid_q]) begin
                    cnv_stb_d   = 1'b1;
                    cnv_data_d  = owner_data;
                    cnv_is_op_d = req_is_op[gid_q];
                    state_d     = ST_FWD;
                end else begin
                    idle_d = idle_q + 1'b1;
                    if (idle_q == CW'(TIMEOUT - 2)) begin
                        cnv_stb_d   = 1'b1;
                        cnv_is_op_d = 1'b1;
                        cnv_data_d  = DATA_W'(EQ_CODE);
                        state_d     = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnv_ack) begin
                    cnv_stb_d = 1'b0;
                    state_d   = ST_ABORT;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                gvld_d  = 1'b0;
                ptr_d   = ptr_next;
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                abort_d = 1'b1;
                gvld_d  = 1'b0;
                ptr_d   = ptr_next;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops any open session without a flush
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gid_q       <= '0;
            gvld_q      <= 1'b0;
            cnv_stb_q   <= 1'b0;
            cnv_data_q  <= '0;
            cnv_is_op_q <= 1'b0;
            req_ack_q   <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gid_q       <= gid_d;
            gvld_q      <= gvld_d;
            cnv_stb_q   <= cnv_stb_d;
            cnv_data_q  <= cnv_data_d;
            cnv_is_op_q <= cnv_is_op_d;
            req_ack_q   <= req_ack_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            idle_q      <= idle_d;
        end
    end

    assign req_ack       = req_ack_q;
    assign cnv_stb       = cnv_stb_q;
    assign cnv_data      = cnv_data_q;
    assign cnv_is_op     = cnv_is_op_q;
    assign grant_valid   = gvld_q;
    assign grant_id      = gid_q;
    assign session_done  = done_q;
    assign session_abort = abort_q;

endmodule

// File: tb/tb_rpn_session_arbiter.sv
// Directed bench for rpn_session_arbiter with token-source and converter models.
// Sources hold each token until req_ack; converter acks after a programmable delay.
// Event log records req_ack source ids, 8 for session_done, 9 for session_abort.
module tb_rpn_session_arbiter;
    import rpn_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int IW = $clog2(N);

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [N-1:0]    req_stb   = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic [N-1:0]    req_is_op = '0;
    logic [N-1:0]    req_ack;
    logic            cnv_stb;
    logic [DW-1:0]   cnv_data;
    logic            cnv_is_op;
    logic            cnv_ack = 1'b0;
    logic            grant_valid;
    logic [IW-1:0]   grant_id;
    logic            session_done;
    logic            session_abort;

    rpn_session_arbiter #(.N_REQ(N), .DATA_W(DW), .EQ_CODE(4), .TIMEOUT(TO)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_stb       (req_stb),
        .req_data      (req_data),
        .req_is_op     (req_is_op),
        .req_ack       (req_ack),
        .cnv_stb       (cnv_stb),
        .cnv_data      (cnv_data),
        .cnv_is_op     (cnv_is_op),
        .cnv_ack       (cnv_ack),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .session_done  (session_done),
        .session_abort (session_abort)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- source model ----------------
    logic [32:0]  stok [N][32];
    int           slen [N] = '{default: 0};
    int           spos [N] = '{default: 0};
    logic [N-1:0] drop = '0;

    always @(negedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) spos[i] = spos[i] + 1;
            if (spos[i] < slen[i]) begin
                req_stb[i]             = !drop[i];
                req_is_op[i]           = stok[i][spos[i]][32];
                req_data[i*DW +: DW]   = stok[i][spos[i]][31:0];
            end else begin
                req_stb[i] = 1'b0;
            end
        end
    end

    // ---------------- converter model ----------------
    int          cnv_dly  = 2;
    logic        cnv_hold = 1'b0;
    int          ccnt     = 0;
    logic [32:0] cnv_log[$];

    always @(negedge CLK) begin
        if (RST) begin
            cnv_ack = 1'b0;
            ccnt    = 0;
        end else if (cnv_ack) begin
            cnv_ack = 1'b0;
        end else if (cnv_stb && !cnv_hold) begin
            if (ccnt >= cnv_dly - 1) begin
                cnv_ack = 1'b1;
                ccnt    = 0;
                cnv_log.push_back({cnv_is_op, cnv_data});
            end else begin
                ccnt++;
            end
        end
    end

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            ev_q[$];
    int            evc_q[$];
    int            gnt_q[$];
    int            srise_q[$];
    int            onehot_bad = 0;
    int            gid_chg = 0;
    logic          prev_gv = 1'b0;
    logic          prev_stb = 1'b0;
    logic [IW-1:0] prev_gid = '0;

    always @(negedge CLK) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) begin
                ev_q.push_back(i);
                evc_q.push_back(cyc);
            end
        end
        if ($countones(req_ack) > 1) onehot_bad++;
        if (session_done) begin ev_q.push_back(8); evc_q.push_back(cyc); end
        if (session_abort) begin ev_q.push_back(9); evc_q.push_back(cyc); end
        if (grant_valid && !prev_gv) gnt_q.push_back(int'(grant_id));
        if (grant_valid && prev_gv && grant_id != prev_gid) gid_chg++;
        if (cnv_stb && !prev_stb) srise_q.push_back(cyc);
        prev_gv  = grant_valid;
        prev_gid = grant_id;
        prev_stb = cnv_stb;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_tok(input int src, input logic op, input logic [31:0] d);
        stok[src][slen[src]] = {op, d};
        slen[src] = slen[src] + 1;
    endtask

    function automatic logic [63:0] ev_pack(input int base, input int n);
        logic [63:0] r;
        int v;
        r = '0;
        for (int k = 0; k < n; k++) begin
            v = (base + k < ev_q.size()) ? ev_q[base + k] : 15;
            r = (r << 4) | 64'(v[3:0]);
        end
        return r;
    endfunction

    function automatic logic [63:0] gnt_pack(input int base, input int n);
        logic [63:0] r;
        int v;
        r = '0;
        for (int k = 0; k < n; k++) begin
            v = (base + k < gnt_q.size()) ? gnt_q[base + k] : 15;
            r = (r << 4) | 64'(v[3:0]);
        end
        return r;
    endfunction

    function automatic logic [32:0] tok_at(input int idx);
        return (idx < cnv_log.size()) ? cnv_log[idx] : 33'h1_ffff_ffff;
    endfunction

    function automatic logic [63:0] outs();
        return 64'({req_ack, cnv_stb, cnv_is_op, grant_valid, grant_id,
                    session_done, session_abort, cnv_data});
    endfunction

    task automatic wait_ev(input string tag, input int n);
        int b = 0;
        while (ev_q.size() < n && b < 3000) begin
            @(negedge CLK);
            b++;
        end
        chk(tag, 64'(ev_q.size() >= n), 64'd1);
    endtask

    task automatic wait_stb(input string tag);
        int b = 0;
        while (!cnv_stb && b < 200) begin
            @(negedge CLK);
            b++;
        end
        chk(tag, 64'(cnv_stb), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    int be, bg, bc, b2;

    initial begin
        repeat (3) @(negedge CLK);
        chk("reset_outputs", outs(), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("idle_no_grant", 64'(grant_valid), 64'd0);

        // simultaneous src1/src2 after reset: src1 completes before src2 is touched
        be = ev_q.size(); bg = gnt_q.size(); bc = cnv_log.size();
        add_tok(1, 1'b0, 32'd1); add_tok(1, 1'b1, 32'(OP_EQ));
        add_tok(2, 1'b0, 32'd9); add_tok(2, 1'b1, 32'(OP_EQ));
        wait_ev("t2_wait", be + 6);
        chk("t2_events", ev_pack(be, 6), 64'h118228);
        chk("t2_grants", gnt_pack(bg, 2), 64'h12);
        chk("t2_tok2", 64'(tok_at(bc + 2)), 64'h0_0000_0009);

        // src0: 3 + 4 =
        repeat (2) @(negedge CLK);
        be = ev_q.size(); bg = gnt_q.size(); bc = cnv_log.size();
        add_tok(0, 1'b0, 32'd3); add_tok(0, 1'b1, 32'(OP_ADD));
        add_tok(0, 1'b0, 32'd4); add_tok(0, 1'b1, 32'(OP_EQ));
        wait_ev("t1_wait", be + 5);
        chk("t1_events", ev_pack(be, 5), 64'h00008);
        chk("t1_grant", gnt_pack(bg, 1), 64'h0);
        chk("t1_tok0", 64'(tok_at(bc + 0)), 64'h0_0000_0003);
        chk("t1_tok1", 64'(tok_at(bc + 1)), 64'h1_0000_0002);
        chk("t1_tok2", 64'(tok_at(bc + 2)), 64'h0_0000_0004);
        chk("t1_tok3", 64'(tok_at(bc + 3)), 64'h1_0000_0004);

        // src0: 5 * then stall -> flush '=' and abort
        repeat (2) @(negedge CLK);
        be = ev_q.size(); bc = cnv_log.size();
        add_tok(0, 1'b0, 32'd5); add_tok(0, 1'b1, 32'(OP_MUL));
        wait_ev("t3_wait", be + 3);
        chk("t3_events", ev_pack(be, 3), 64'h009);
        chk("t3_flush_tok", 64'(tok_at(bc + 2)), 64'h1_0000_0004);
        chk("t3_idle_cycles", 64'(srise_q[srise_q.size()-1] - evc_q[be + 1]), 64'(TO));
        chk("t3_released", 64'(grant_valid), 64'd0);

        // pointer now 1: src0 and src1 together -> src1 first
        repeat (2) @(negedge CLK);
        be = ev_q.size(); bg = gnt_q.size();
        add_tok(0, 1'b1, 32'(OP_EQ)); add_tok(1, 1'b1, 32'(OP_EQ));
        wait_ev("ptr_wait", be + 4);
        chk("ptr_grants", gnt_pack(bg, 2), 64'h10);
        chk("ptr_events", ev_pack(be, 4), 64'h1808);

        // reset while a token is parked on the converter port
        repeat (2) @(negedge CLK);
        be = ev_q.size(); bg = gnt_q.size();
        cnv_hold = 1'b1;
        add_tok(3, 1'b1, 32'(OP_EQ));
        wait_stb("t5_fwd");
        @(negedge CLK);
        b2 = ev_q.size();
        RST = 1'b1;
        @(negedge CLK);
        chk("t5_rst_outputs", outs(), 64'd0);
        chk("t5_no_ack", 64'(ev_q.size()), 64'(b2));
        RST = 1'b0;
        cnv_hold = 1'b0;
        wait_ev("t5_wait", be + 2);
        chk("t5_events", ev_pack(be, 2), 64'h38);
        chk("t5_regrant", gnt_pack(bg, 2), 64'h33);

        // every source busy: order 0,1,2,3,0
        repeat (2) @(negedge CLK);
        be = ev_q.size(); bg = gnt_q.size();
        add_tok(0, 1'b1, 32'(OP_EQ)); add_tok(0, 1'b1, 32'(OP_EQ));
        add_tok(1, 1'b1, 32'(OP_EQ)); add_tok(2, 1'b1, 32'(OP_EQ));
        add_tok(3, 1'b1, 32'(OP_EQ));
        wait_ev("t4_wait", be + 10);
        chk("t4_grants", gnt_pack(bg, 5), 64'h01230);
        chk("t4_events", ev_pack(be, 10), 64'h0818283808);

        // src1 drops stb while its token is in flight
        repeat (2) @(negedge CLK);
        be = ev_q.size(); bc = cnv_log.size();
        cnv_dly = 5;
        add_tok(1, 1'b0, 32'd7);
        wait_stb("t6_fwd");
        @(negedge CLK);
        drop[1] = 1'b1;
        wait_ev("t6_wait", be + 2);
        chk("t6_events", ev_pack(be, 2), 64'h19);
        chk("t6_tok", 64'(tok_at(bc)), 64'h0_0000_0007);
        chk("t6_flush_tok", 64'(tok_at(bc + 1)), 64'h1_0000_0004);
        chk("t6_idle_cycles", 64'(srise_q[srise_q.size()-1] - evc_q[be]), 64'(TO));
        drop[1] = 1'b0;

        repeat (3) @(negedge CLK);
        chk("ack_onehot", 64'(onehot_bad), 64'd0);
        chk("grant_id_stable", 64'(gid_chg), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
